// File: rtl/pb_debounce_if.sv
// -----------------------------------------------------------------------------
// pb_debounce_if
//
// Groups the push-button signals that pass between the button side and the
// debouncer.
//
// Signals:
//   PB_n_raw   : raw button pin, asynchronous, 0 = pressed (driven by master)
//   PB_clean   : debounced level, 1 = pressed               (driven by slave)
//   long_press : single-cycle long-hold pulse                (driven by slave)
//
// Modports:
//   master : the button / pad side (drives the raw pin, observes the results)
//   slave  : the debouncer (pb_debounce)
// -----------------------------------------------------------------------------
interface pb_debounce_if;

    logic PB_n_raw;
    logic PB_clean;
    logic long_press;

    modport master (
        output PB_n_raw,
        input  PB_clean,
        input  long_press
    );

    modport slave (
        input  PB_n_raw,
        output PB_clean,
        output long_press
    );

endinterface : pb_debounce_if

// File: rtl/pb_debounce.sv
// -----------------------------------------------------------------------------
// pb_debounce
//
// Synchronizes and debounces the raw, active-low handlebar mode push button and
// produces a clean active-high level (PB_clean) for the assist-mode toggle
// stage, which edge-detects it. An optional long-press detector emits a single
// cycle pulse once per press when the button is held long enough.
//
// Parameters:
//   DB_CYCLES   : consecutive stable samples needed to accept a level change
//                 (>= 2). Default 50000 = 1 ms at 50 MHz.
//   LONG_CYCLES : clocks PB_clean must stay high before long_press fires
//                 (>= 1). Only used when PB_LONG_PRESS_EN is defined.
//
// Ports:
//   clk   : system clock (single clock domain)
//   rst_n : asynchronous active-low reset
//   pb    : pb_debounce_if.slave
//             pb.PB_n_raw   in  raw pin, 0 = pressed
//             pb.PB_clean   out debounced level, 1 = pressed
//             pb.long_press out one-cycle long-hold pulse
//
// Build option:
//   PB_LONG_PRESS_EN : when defined, the long-press counter, its done flag and
//                      the long_press register are built. When undefined,
//                      long_press is tied to 0 and LONG_CYCLES is ignored.
//                      Debounce behaviour is the same in both builds.
// -----------------------------------------------------------------------------
module pb_debounce #(
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic          clk,
    input  logic          rst_n,
    pb_debounce_if.slave  pb
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int DW = $clog2(DB_CYCLES + 1);

    // Value of dcnt on the edge that accepts the last required sample: dcnt is
    // loaded with 1 on entry to a wait state (that edge counts as sample one).
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,   // stable released
        PRESS_WAIT   = 2'b01,   // seeing pressed samples, not yet accepted
        PRESSED      = 2'b10,   // stable pressed
        RELEASE_WAIT = 2'b11    // seeing released samples, not yet accepted
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic          s1_r;
    logic          s2_r;
    state_t        state_r;
    logic [DW-1:0] dcnt_r;
    logic          pb_clean_r;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer; both stages reset to the released level (1).
    // -------------------------------------------------------------------------
    // Synchronize the asynchronous button pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= pb.PB_n_raw;
            s2_r <= s1_r;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM. PB_clean is registered alongside the state and is loaded
    // with the Moore value of the *next* state, so it changes on the same edge
    // as the state and never glitches inside a wait window.
    // A sample of the opposite level inside a wait window returns to the stable
    // state it came from; a new window must then collect DB_CYCLES fresh
    // samples.
    // -------------------------------------------------------------------------
    // State register, debounce counter and clean-level output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dcnt_r     <= DW'(0);
            pb_clean_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!s2_r) begin
                        state_r    <= PRESS_WAIT;
                        dcnt_r     <= DW'(1);
                        pb_clean_r <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b0;
                    end
                end

                PRESS_WAIT: begin
                    if (s2_r) begin
                        // bounce back to released
                        state_r    <= IDLE;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b0;
                    end else if (dcnt_r == DB_LAST) begin
                        state_r    <= PRESSED;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b1;
                    end else begin
                        state_r    <= PRESS_WAIT;
                        dcnt_r     <= dcnt_r + DW'(1);
                        pb_clean_r <= 1'b0;
                    end
                end

                PRESSED: begin
                    if (s2_r) begin
                        state_r    <= RELEASE_WAIT;
                        dcnt_r     <= DW'(1);
                        pb_clean_r <= 1'b1;
                    end else begin
                        state_r    <= PRESSED;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b1;
                    end
                end

                RELEASE_WAIT: begin
                    if (!s2_r) begin
                        // bounce back to pressed
                        state_r    <= PRESSED;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b1;
                    end else if (dcnt_r == DB_LAST) begin
                        state_r    <= IDLE;
                        dcnt_r     <= DW'(0);
                        pb_clean_r <= 1'b0;
                    end else begin
                        state_r    <= RELEASE_WAIT;
                        dcnt_r     <= dcnt_r + DW'(1);
                        pb_clean_r <= 1'b1;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    dcnt_r     <= DW'(0);
                    pb_clean_r <= 1'b0;
                end
            endcase
        end
    end

    assign pb.PB_clean = pb_clean_r;

`ifdef PB_LONG_PRESS_EN
    // -------------------------------------------------------------------------
    // Long-press detector.
    // lcnt counts clocks spent in PRESSED; it holds in RELEASE_WAIT so a
    // release bounce does not restart the hold time, and clears in the
    // released states. done blocks auto-repeat until the button is released.
    // PB_clean rises on edge P; lcnt is 0 there and reaches LONG_CYCLES-1 by
    // edge P+LONG_CYCLES, which is where the pulse is registered.
    // The pulse can only fire from PRESSED, so a release that completes out of
    // RELEASE_WAIT can never coincide with a pulse.
    // -------------------------------------------------------------------------
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt_r;
    logic          done_r;
    logic          long_press_r;

    // Hold-time counter, one-shot flag and long_press pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_r       <= LW'(0);
            done_r       <= 1'b0;
            long_press_r <= 1'b0;
        end else begin
            case (state_r)
                PRESSED: begin
                    if (!done_r && (lcnt_r == LONG_LAST)) begin
                        lcnt_r       <= lcnt_r;
                        done_r       <= 1'b1;
                        long_press_r <= 1'b1;
                    end else if (!done_r) begin
                        lcnt_r       <= lcnt_r + LW'(1);
                        done_r       <= 1'b0;
                        long_press_r <= 1'b0;
                    end else begin
                        lcnt_r       <= lcnt_r;
                        done_r       <= 1'b1;
                        long_press_r <= 1'b0;
                    end
                end

                RELEASE_WAIT: begin
                    lcnt_r       <= lcnt_r;
                    done_r       <= done_r;
                    long_press_r <= 1'b0;
                end

                default: begin
                    // IDLE / PRESS_WAIT: released, start the next press fresh
                    lcnt_r       <= LW'(0);
                    done_r       <= 1'b0;
                    long_press_r <= 1'b0;
                end
            endcase
        end
    end

    assign pb.long_press = long_press_r;
`else
    // Long-press logic compiled out: output constant, LONG_CYCLES ignored.
    logic unused_long_cfg_s;
    assign unused_long_cfg_s = (LONG_CYCLES > 0) ? 1'b1 : 1'b0;

    assign pb.long_press = 1'b0;
`endif

endmodule : pb_debounce

// File: tb/tb_pb_debounce.sv
// -----------------------------------------------------------------------------
// tb_pb_debounce
//
// Self-checking bench for pb_debounce with DB_CYCLES=4, LONG_CYCLES=10.
// Edge numbering in the tables: edge 0 is the first rising edge after the pin
// is changed, i.e. the edge at which s1 captures the new value. Outputs are
// sampled 1 time unit after each rising edge. The expected long_press pulse is
// present only when PB_LONG_PRESS_EN is defined; otherwise it is always 0.
// -----------------------------------------------------------------------------
module tb_pb_debounce;

    localparam int DB   = 4;
    localparam int LONG = 10;

`ifdef PB_LONG_PRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    pb_debounce_if ifc ();

    pb_debounce #(
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pb    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pin;      // PB_n_raw driven before the edge
        logic clean;    // expected PB_clean after the edge
        logic lp;       // expected long_press after the edge
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_seg(input logic pin, input logic clean, input logic lp, input int n);
        vec_t v;
        v.pin   = pin;
        v.clean = clean;
        v.lp    = lp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Clean 20-cycle press then release, starting from stable IDLE.
    task automatic add_clean_press();
        add_seg(1'b0, 1'b0, 1'b0, 5);   // edges 0-4  : debouncing the press
        add_seg(1'b0, 1'b1, 1'b0, 10);  // edges 5-14 : pressed
        add_seg(1'b0, 1'b1, LP,   1);   // edge 15    : long press (5 + 10)
        add_seg(1'b0, 1'b1, 1'b0, 4);   // edges 16-19: no repeat
        add_seg(1'b1, 1'b1, 1'b0, 5);   // edges 20-24: debouncing the release
        add_seg(1'b1, 1'b0, 1'b0, 5);   // edges 25-29: released
    endtask

    initial begin
        // ---------------- table fill ----------------
        add_clean_press();
        // Press bounce, then release bounce while pressed, held ~40 cycles.
        add_seg(1'b0, 1'b0, 1'b0, 3);   // e0-2  : low
        add_seg(1'b1, 1'b0, 1'b0, 1);   // e3    : bounce high
        add_seg(1'b0, 1'b0, 1'b0, 5);   // e4-8  : fresh window (k=4)
        add_seg(1'b0, 1'b1, 1'b0, 3);   // e9-11 : accepted at k+5
        add_seg(1'b1, 1'b1, 1'b0, 2);   // e12-13: release bounce, 2 cycles
        add_seg(1'b0, 1'b1, 1'b0, 7);   // e14-20: lcnt held over 2 RELEASE_WAIT edges
        add_seg(1'b0, 1'b1, LP,   1);   // e21   : pulse delayed by exactly 2
        add_seg(1'b0, 1'b1, 1'b0, 18);  // e22-39: held, no repeat
        add_seg(1'b1, 1'b1, 1'b0, 5);   // e40-44: release debounce
        add_seg(1'b1, 1'b0, 1'b0, 5);   // e45-49: released
        add_clean_press();              // second press gives a new pulse

        // ---------------- reset with pin held low ----------------
        rst_n        = 1'b0;
        ifc.PB_n_raw = 1'b0;
        #2;
        check("rst_clean_async", ifc.PB_clean, 1'b0);
        check("rst_long_async", ifc.long_press, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rst_hold_clean[%0d]", i), ifc.PB_clean, 1'b0);
            check($sformatf("rst_hold_long[%0d]", i), ifc.long_press, 1'b0);
        end
        rst_n = 1'b1;
        for (int e = 0; e <= DB; e++) begin
            tick();
            check($sformatf("post_rst_press_e%0d", e), ifc.PB_clean, (e >= DB + 1) ? 1'b1 : 1'b0);
        end
        // release right after acceptance: high for the DB+1 edges of release debounce
        ifc.PB_n_raw = 1'b1;
        for (int e = 0; e <= DB + 1; e++) begin
            tick();
            check($sformatf("short_rel_e%0d", e), ifc.PB_clean, (e >= DB + 1) ? 1'b0 : 1'b1);
            check($sformatf("short_rel_long_e%0d", e), ifc.long_press, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            ifc.PB_n_raw = vecs[i].pin;
            tick();
            check($sformatf("vec%0d_clean", i), ifc.PB_clean, vecs[i].clean);
            check($sformatf("vec%0d_long", i), ifc.long_press, vecs[i].lp);
        end

        // ---------------- async reset during PRESS_WAIT ----------------
        ifc.PB_n_raw = 1'b0;
        for (int i = 0; i < 3; i++) tick();  // PRESS_WAIT after edge 2
        check("pw_clean_before", ifc.PB_clean, 1'b0);
        rst_n = 1'b0;
        #1;
        check("pw_rst_clean", ifc.PB_clean, 1'b0);
        check("pw_rst_long", ifc.long_press, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        // pin still held: a completely new press needing the full debounce
        for (int e = 0; e <= DB + 2; e++) begin
            tick();
            check($sformatf("pw_new_press_e%0d", e), ifc.PB_clean, (e >= DB + 1) ? 1'b1 : 1'b0);
        end

        // ---------------- async reset during PRESSED ----------------
        check("pr_clean_before", ifc.PB_clean, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;  // no clock edge in between
        check("pr_rst_clean", ifc.PB_clean, 1'b0);
        check("pr_rst_long", ifc.long_press, 1'b0);
        ifc.PB_n_raw = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pr_after_clean[%0d]", i), ifc.PB_clean, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on simulated time in case something stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got t=%0t, expected < 200000", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_pb_debounce

// File: doc/pb_debounce.md
# pb_debounce

Debounces and synchronizes the raw, active-low handlebar mode push button and drives the clean active-high level that the assist-mode toggle logic edge-detects to step through assist settings. Two flops synchronize the pin, and a four-state FSM requires DB_CYCLES consecutive stable samples before changing the clean level. An optional long-press detector emits a single-cycle pulse when the button is held, for use by downstream logic.

## Interface
- DB_CYCLES, default 50000: consecutive stable samples required to accept a level change (1 ms at 50 MHz). Legal range is 2 or more.
- LONG_CYCLES, default 50000000: clocks that PB_clean must stay high before long_press fires. Legal range is 1 or more. Used only with PB_LONG_PRESS_EN.
- clk, input, 1: system clock. The block has one clock only.
- rst_n, input, 1: asynchronous active-low reset.
- PB_n_raw, input, 1: raw button pin, asynchronous, 0 = pressed.
- PB_clean, output, 1: debounced level, 1 = pressed. Connects to the tgglMd input of the mode-toggle stage.
- long_press, output, 1: one-cycle pulse marking a long hold. Tied to 0 when the feature is compiled out.

## Operation
- Synchronizer: s1 <= PB_n_raw, then s2 <= s1. Both reset to 1 (released). The FSM samples only s2.
- FSM states: IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed), RELEASE_WAIT. Reset state is IDLE.
- Debounce counter dcnt has width $clog2(DB_CYCLES+1) and resets to 0.
- IDLE:
  - s2==0: go to PRESS_WAIT, dcnt=1.
  - Otherwise stay in IDLE, dcnt=0.
- PRESS_WAIT:
  - s2==1 (bounce): go to IDLE, dcnt=0.
  - s2==0 and dcnt==DB_CYCLES-1: go to PRESSED, dcnt=0.
  - Otherwise dcnt++.
- PRESSED and RELEASE_WAIT mirror IDLE and PRESS_WAIT with the polarity of s2 inverted. RELEASE_WAIT completes to IDLE and bounces back to PRESSED.
- PB_clean is a Moore output: it is 1 in PRESSED and RELEASE_WAIT, and 0 otherwise. It never glitches within a bounce window.
- Long-press counter lcnt has width $clog2(LONG_CYCLES+1) and resets to 0. A done flag resets to 0.
  - lcnt increments on every clock spent in PRESSED while done==0.
  - lcnt holds in RELEASE_WAIT, so a release bounce does not restart the hold time.
  - lcnt and done clear when the FSM enters IDLE.
  - When lcnt reaches LONG_CYCLES-1 while in PRESSED, long_press is registered high for exactly one cycle and done is set.
  - Result: at most one pulse per press, with no auto-repeat.
- Reset mid-operation: all state returns to IDLE immediately, both outputs go to 0, and the synchronizer returns to 1. A button still held after reset is treated as a new press and needs the full debounce again.

## Timing
- Reset values: PB_clean=0, long_press=0, state=IDLE, dcnt=0, lcnt=0, s1=s2=1.
- Press latency, defined from edge k, the first edge at which s1 captures 0:
  - s2=0 at edge k+1.
  - s2 is sampled low on DB_CYCLES consecutive edges, k+2 through k+DB_CYCLES+1.
  - PB_clean rises after edge k+DB_CYCLES+1.
- Release latency is identical, with the polarity inverted.
- Any opposite sample inside a wait window aborts the window. A new window needs a full DB_CYCLES fresh samples.
- Pulse width: the shortest press that PB_clean reports is DB_CYCLES samples long. PB_clean stays high for at least DB_CYCLES+1 cycles, covering the release debounce.
- long_press is high in the single cycle starting exactly LONG_CYCLES clocks after PB_clean rises, provided the FSM did not pass through RELEASE_WAIT in that interval.
- If a release completes on the same edge the pulse would fire, the release wins and no pulse is issued.

## Configuration
- PB_LONG_PRESS_EN defined: lcnt, done and the long_press register are present and behave as described above.
- PB_LONG_PRESS_EN undefined: that logic is removed and long_press is tied to 1'b0. LONG_CYCLES is ignored.
- Debounce behaviour is identical in both builds.

## Test plan
All scenarios use DB_CYCLES=4 and LONG_CYCLES=10.
- Reset: hold rst_n=0 with PB_n_raw=0 -> PB_clean=0 and long_press=0 throughout. Release reset with the pin held low -> PB_clean rises exactly 5 edges after the first s1 capture.
- Clean press: drive PB_n_raw=0 before edge 0 -> PB_clean=1 from edge 5. Drive it to 1 before edge 20 -> PB_clean=0 from edge 25.
- Bounce: drive pin low 3 cycles, high 1, low steady -> PB_clean rises only after 4 consecutive low samples following the last high. No glitch at any time.
- Release bounce: while PRESSED, pulse the pin high for 2 cycles -> PB_clean stays 1 and lcnt does not reset.
- Long press: hold 30 cycles -> long_press is high for exactly 1 cycle, 10 clocks after PB_clean rises, and does not repeat. Press again -> a new pulse. Build without PB_LONG_PRESS_EN -> long_press stays 0.
- Async reset mid-hold, asserted during PRESS_WAIT and again during PRESSED -> outputs clear immediately, without waiting for a clock.
